// File: rtl/mem_port_arbiter.sv
// Round-robin share of the data RAM port between fetch and load/store.
// Sub-word stores run as a two-cycle read-modify-write.
module mem_port_arbiter #(
  parameter int A_WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               f_req,
  input  logic [A_WIDTH-1:0] f_addr,
  output logic               f_gnt,
  output logic               f_rvalid,
  output logic [31:0]        f_rdata,
  input  logic               d_req,
  input  logic               d_we,
  input  logic [A_WIDTH-1:0] d_addr,
  input  logic [2:0]         d_bytes,
  input  logic [31:0]        d_wd,
  output logic               d_gnt,
  output logic               d_rvalid,
  output logic [31:0]        d_rdata,
  output logic [A_WIDTH-1:0] ram_addr,
  output logic               ram_we,
  output logic [31:0]        ram_wd,
  input  logic [31:0]        ram_dout
);

  typedef enum logic {IDLE, RMW} state_t;

  state_t             state;
  logic               last_d;
  logic [A_WIDTH-1:0] rmw_addr;
  logic [31:0]        rmw_wd;

  logic        idle;
  logic        sub_st;
  logic        word_st;
  logic [31:0] ld;
  logic [31:0] merged;

  assign idle    = (state == IDLE);
  // last_d set means data won last, so fetch has priority on contention
  assign f_gnt   = idle & f_req & (~d_req | last_d);
  assign d_gnt   = idle & d_req & (~f_req | ~last_d);
  assign sub_st  = d_we & ((d_bytes == 3'b000) | (d_bytes == 3'b001));
  assign word_st = d_we & (d_bytes == 3'b010);

  always_comb begin
    ld = '0;
    case (d_bytes)
      3'b000:  ld = {{24{ram_dout[7]}}, ram_dout[7:0]};
      3'b001:  ld = {{16{ram_dout[15]}}, ram_dout[15:0]};
      3'b010:  ld = ram_dout;
      3'b100:  ld = {24'd0, ram_dout[7:0]};
      3'b101:  ld = {16'd0, ram_dout[15:0]};
      default: ld = '0;
    endcase
  end

  assign merged = d_bytes[0] ? {ram_dout[31:16], d_wd[15:0]}
                             : {ram_dout[31:8], d_wd[7:0]};

  assign ram_addr = !idle ? rmw_addr :
                    d_gnt ? d_addr : f_addr;
  assign ram_we   = !idle | (d_gnt & word_st);
  assign ram_wd   = idle ? d_wd : rmw_wd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      last_d   <= 1'b1;
      rmw_addr <= '0;
      rmw_wd   <= '0;
      f_rvalid <= 1'b0;
      f_rdata  <= '0;
      d_rvalid <= 1'b0;
      d_rdata  <= '0;
    end else begin
      f_rvalid <= f_gnt;
      d_rvalid <= 1'b0;
      if (f_gnt)
        f_rdata <= ram_dout;
      if (f_gnt | d_gnt)
        last_d <= d_gnt;
      case (state)
        IDLE: begin
          if (d_gnt) begin
            d_rdata <= d_we ? 32'd0 : ld;
            if (sub_st) begin
              rmw_addr <= d_addr;
              rmw_wd   <= merged;
              state    <= RMW;
            end else begin
              d_rvalid <= 1'b1;
            end
          end
        end
        RMW: begin
          d_rvalid <= 1'b1;
          d_rdata  <= '0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: byte RAM model, directed cases and
// randomized traffic against a transaction-level reference.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        f_req;
  logic [31:0] f_addr;
  logic        f_gnt;
  logic        f_rvalid;
  logic [31:0] f_rdata;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [2:0]  d_bytes;
  logic [31:0] d_wd;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic [31:0] ram_addr;
  logic        ram_we;
  logic [31:0] ram_wd;
  logic [31:0] ram_dout;

  logic [7:0]  ram [256];
  logic [7:0]  ref_mem [256];
  logic        tb_wr;
  logic [7:0]  tb_wa;
  logic [31:0] tb_wd;

  int n_cmp = 0;
  int n_err = 0;

  bit          busy;
  bit          last_d;
  bit          efv;
  bit          cur_dv;
  bit          nxt_dv;
  bit          g_f;
  bit          g_d;
  bit          seen_f;
  bit          seen_dv;
  logic [31:0] efd;
  logic [31:0] cur_dd;
  logic [31:0] nxt_dd;
  logic [7:0]  rmw_a;
  logic [31:0] rmw_w;

  logic [2:0] codes [7] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd7};

  mem_port_arbiter #(.A_WIDTH(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .f_req    (f_req),
    .f_addr   (f_addr),
    .f_gnt    (f_gnt),
    .f_rvalid (f_rvalid),
    .f_rdata  (f_rdata),
    .d_req    (d_req),
    .d_we     (d_we),
    .d_addr   (d_addr),
    .d_bytes  (d_bytes),
    .d_wd     (d_wd),
    .d_gnt    (d_gnt),
    .d_rvalid (d_rvalid),
    .d_rdata  (d_rdata),
    .ram_addr (ram_addr),
    .ram_we   (ram_we),
    .ram_wd   (ram_wd),
    .ram_dout (ram_dout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_we) begin
      for (int i = 0; i < 4; i++)
        ram[ram_addr[7:0] + 8'(i)] <= ram_wd[8*i +: 8];
    end else if (tb_wr) begin
      for (int i = 0; i < 4; i++)
        ram[tb_wa + 8'(i)] <= tb_wd[8*i +: 8];
    end
  end

  always_comb begin
    ram_dout = '0;
    for (int i = 0; i < 4; i++)
      ram_dout[8*i +: 8] = ram[ram_addr[7:0] + 8'(i)];
  end

  function automatic logic [31:0] ref_word(logic [7:0] a);
    logic [31:0] r;
    for (int i = 0; i < 4; i++)
      r[8*i +: 8] = ref_mem[a + 8'(i)];
    return r;
  endfunction

  function automatic logic [31:0] ram_word(logic [7:0] a);
    logic [31:0] r;
    for (int i = 0; i < 4; i++)
      r[8*i +: 8] = ram[a + 8'(i)];
    return r;
  endfunction

  function automatic void ref_write(logic [7:0] a, logic [31:0] w);
    for (int i = 0; i < 4; i++)
      ref_mem[a + 8'(i)] = w[8*i +: 8];
  endfunction

  function automatic logic [31:0] ext(logic [31:0] w, logic [2:0] c);
    case (c)
      3'd0:    return 32'($signed(w[7:0]));
      3'd1:    return 32'($signed(w[15:0]));
      3'd2:    return w;
      3'd4:    return {24'd0, w[7:0]};
      3'd5:    return {16'd0, w[15:0]};
      default: return 32'd0;
    endcase
  endfunction

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    busy   = 1'b0;
    last_d = 1'b1;
    efv    = 1'b0;
    cur_dv = 1'b0;
    nxt_dv = 1'b0;
    cur_dd = '0;
    nxt_dd = '0;
  endtask

  // One clock: check outputs at negedge, advance the model, resume after posedge
  task automatic step();
    bit         ewe;
    logic [7:0] da;
    @(negedge clk);
    g_f = !busy && f_req && (!d_req || last_d);
    g_d = !busy && d_req && (!f_req || !last_d);
    seen_f  = f_gnt;
    seen_dv = d_rvalid;
    check("f_gnt", 32'(f_gnt), 32'(g_f));
    check("d_gnt", 32'(d_gnt), 32'(g_d));
    check("f_rvalid", 32'(f_rvalid), 32'(efv));
    if (efv) check("f_rdata", f_rdata, efd);
    check("d_rvalid", 32'(d_rvalid), 32'(cur_dv));
    if (cur_dv) check("d_rdata", d_rdata, cur_dd);
    ewe = busy || (g_d && d_we && d_bytes == 3'd2);
    check("ram_we", 32'(ram_we), 32'(ewe));
    if (busy) begin
      check("rmw_addr", ram_addr, {24'd0, rmw_a});
      check("rmw_wd", ram_wd, rmw_w);
    end else if (ewe) begin
      check("sw_addr", ram_addr, d_addr);
      check("sw_wd", ram_wd, d_wd);
    end
    efv = g_f;
    if (g_f) efd = ref_word(f_addr[7:0]);
    cur_dv = nxt_dv;
    cur_dd = nxt_dd;
    nxt_dv = 1'b0;
    nxt_dd = '0;
    if (busy) begin
      ref_write(rmw_a, rmw_w);
      busy = 1'b0;
    end
    if (g_d) begin
      da = d_addr[7:0];
      if (!d_we) begin
        cur_dv = 1'b1;
        cur_dd = ext(ref_word(da), d_bytes);
      end else if (d_bytes == 3'd0 || d_bytes == 3'd1) begin
        busy  = 1'b1;
        rmw_a = da;
        rmw_w = ref_word(da);
        if (d_bytes == 3'd0) rmw_w[7:0] = d_wd[7:0];
        else rmw_w[15:0] = d_wd[15:0];
        nxt_dv = 1'b1;
      end else begin
        if (d_bytes == 3'd2) ref_write(da, d_wd);
        cur_dv = 1'b1;
        cur_dd = '0;
      end
    end
    if (g_f || g_d) last_d = g_d;
    @(posedge clk);
    #1;
  endtask

  task automatic poke(logic [7:0] a, logic [31:0] w);
    f_req = 1'b0;
    d_req = 1'b0;
    step();
    step();
    tb_wr = 1'b1;
    tb_wa = a;
    tb_wd = w;
    ref_write(a, w);
    step();
    tb_wr = 1'b0;
  endtask

  task automatic do_load(logic [2:0] code, logic [31:0] exp);
    d_req   = 1'b1;
    d_we    = 1'b0;
    d_addr  = 32'h30;
    d_bytes = code;
    step();
    d_req = 1'b0;
    check("load_val", d_rdata, exp);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    #1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    rst_n   = 1'b0;
    f_req   = 1'b0;
    f_addr  = '0;
    d_req   = 1'b0;
    d_we    = 1'b0;
    d_addr  = '0;
    d_bytes = '0;
    d_wd    = '0;
    tb_wr   = 1'b0;
    tb_wa   = '0;
    tb_wd   = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_f_rvalid", 32'(f_rvalid), 32'd0);
    check("rst_d_rvalid", 32'(d_rvalid), 32'd0);
    check("rst_f_rdata", f_rdata, 32'd0);
    check("rst_d_rdata", d_rdata, 32'd0);
    check("rst_ram_we", 32'(ram_we), 32'd0);
    check("rst_ram_addr", ram_addr, 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 64; i++)
      poke(8'(i * 4), $urandom);

    poke(8'h10, 32'h8899AABB);
    f_req  = 1'b1;
    f_addr = 32'h10;
    step();
    f_req = 1'b0;
    check("fetch_valid", 32'(f_rvalid), 32'd1);
    check("fetch_data", f_rdata, 32'h8899AABB);

    apply_reset();
    f_req   = 1'b1;
    d_req   = 1'b1;
    d_we    = 1'b0;
    d_bytes = 3'd2;
    f_addr  = 32'h10;
    d_addr  = 32'h30;
    for (int i = 0; i < 4; i++) begin
      step();
      check("cont_order", 32'(seen_f), (i % 2 == 0) ? 32'd1 : 32'd0);
    end
    f_req = 1'b0;
    d_req = 1'b0;

    poke(8'h20, 32'h11223344);
    d_req   = 1'b1;
    d_we    = 1'b1;
    d_bytes = 3'd0;
    d_addr  = 32'h20;
    d_wd    = 32'hFFFFFFA5;
    step();
    d_req  = 1'b0;
    f_req  = 1'b1;
    f_addr = 32'h20;
    step();
    check("sb_fetch_wait", 32'(seen_f), 32'd0);
    step();
    f_req = 1'b0;
    check("sb_fetch_gnt", 32'(seen_f), 32'd1);
    check("sb_done", 32'(seen_dv), 32'd1);
    check("sb_word", f_rdata, 32'h112233A5);

    poke(8'h30, 32'h000080F0);
    do_load(3'd0, 32'hFFFFFFF0);
    do_load(3'd4, 32'h000000F0);
    do_load(3'd1, 32'hFFFF80F0);
    do_load(3'd5, 32'h000080F0);
    do_load(3'd2, 32'h000080F0);
    do_load(3'd7, 32'h00000000);

    poke(8'h40, 32'hDEADBEEF);
    d_req   = 1'b1;
    d_we    = 1'b1;
    d_bytes = 3'd1;
    d_addr  = 32'h40;
    d_wd    = 32'h00001234;
    step();
    d_we    = 1'b0;
    d_bytes = 3'd2;
    step();
    step();
    d_req = 1'b0;
    check("sh_lw", d_rdata, 32'hDEAD1234);

    poke(8'h50, 32'hCAFEF00D);
    d_req   = 1'b1;
    d_we    = 1'b1;
    d_bytes = 3'd0;
    d_addr  = 32'h50;
    d_wd    = 32'h00000077;
    step();
    d_req   = 1'b0;
    d_we    = 1'b0;
    d_wd    = '0;
    d_addr  = '0;
    d_bytes = '0;
    f_addr  = '0;
    rst_n   = 1'b0;
    #1;
    check("rmw_rst_we", 32'(ram_we), 32'd0);
    check("rmw_rst_gnt", {30'd0, f_gnt, d_gnt}, 32'd0);
    check("rmw_rst_valid", {30'd0, f_rvalid, d_rvalid}, 32'd0);
    check("rmw_rst_f_rdata", f_rdata, 32'd0);
    check("rmw_rst_d_rdata", d_rdata, 32'd0);
    check("rmw_rst_addr", ram_addr, 32'd0);
    check("rmw_rst_wd", ram_wd, 32'd0);
    @(posedge clk);
    #1;
    check("rmw_rst_ram", ram_word(8'h50), 32'hCAFEF00D);
    check("rmw_rst_dv", 32'(d_rvalid), 32'd0);
    rst_n = 1'b1;
    model_reset();
    f_req   = 1'b1;
    d_req   = 1'b1;
    d_bytes = 3'd2;
    f_addr  = 32'h50;
    d_addr  = 32'h50;
    step();
    check("rst_first_fetch", 32'(seen_f), 32'd1);
    f_req = 1'b0;
    d_req = 1'b0;
    step();

    for (int n = 0; n < 3000; n++) begin
      if (!f_req || g_f || $urandom_range(0, 19) == 0) begin
        f_req  = ($urandom_range(0, 2) != 0);
        f_addr = 32'($urandom_range(0, 252));
      end
      if (!d_req || g_d || $urandom_range(0, 19) == 0) begin
        d_req   = ($urandom_range(0, 2) != 0);
        d_we    = 1'($urandom_range(0, 1));
        d_addr  = 32'($urandom_range(0, 252));
        d_bytes = codes[$urandom_range(0, 6)];
        d_wd    = $urandom;
      end
      step();
    end
    f_req = 1'b0;
    d_req = 1'b0;
    repeat (3) step();
    for (int i = 0; i < 64; i++)
      check("final_mem", ram_word(8'(i * 4)), ref_word(8'(i * 4)));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
